// File: rtl/adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// adc_scan_sequencer
//
// Autonomous scan controller wrapped around an MCP3202 SPI ADC controller.
// Issues a periodic one-cycle conversion request, alternating CH0/CH1,
// captures each 12-bit result when the controller's chip-select returns high,
// and publishes boxcar averages of 2^AVG_LOG2 samples per channel together
// with a one-cycle valid strobe. A stalled SPI transaction (chip-select phase
// exceeding TIMEOUT cycles) sets a sticky error flag and the sample is dropped.
//
// Parameters:
//   SAMPLE_PERIOD  clk cycles between successive start pulses (2..65535)
//   AVG_LOG2       log2 of samples averaged per channel (0..4)
//   TIMEOUT        max clk cycles spent in either chip-select wait (1..65535)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   scan run control
//   start        out  one-cycle conversion request
//   sgl_diff     out  constant 1 (single-ended)
//   odd_sign     out  channel select, 0 = CH0, 1 = CH1
//   msb_lsb      out  constant 1 (MSB-first)
//   chipselect   in   SPI chip-select, low while a conversion runs
//   adc_data     in   12-bit result, stable from chipselect rising
//   ch0_avg      out  latest CH0 average
//   ch1_avg      out  latest CH1 average
//   avg_valid    out  one-cycle strobe marking new averages
//   timeout_err  out  sticky stall flag
// -----------------------------------------------------------------------------
module adc_scan_sequencer #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 2,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        start,
  output logic        sgl_diff,
  output logic        odd_sign,
  output logic        msb_lsb,
  input  logic        chipselect,
  input  logic [11:0] adc_data,
  output logic [11:0] ch0_avg,
  output logic [11:0] ch1_avg,
  output logic        avg_valid,
  output logic        timeout_err
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(1 << AVG_LOG2);
  localparam logic [15:0]      PERIOD_LOAD  = 16'(SAMPLE_PERIOD - 1);
  localparam logic [15:0]      TIMEOUT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_LOW,
    WAIT_HIGH,
    CAPTURE,
    GAP
  } state_t;

  state_t           state;
  logic [15:0]      period_cnt;
  logic [15:0]      wait_cnt;
  logic [ACC_W-1:0] acc0;
  logic [ACC_W-1:0] acc1;
  logic [CNT_W-1:0] pair_cnt;

  logic [ACC_W-1:0] acc0_sum;
  logic [ACC_W-1:0] acc1_sum;
  logic [CNT_W-1:0] pair_cnt_inc;

  // The accumulators are sized so 2^AVG_LOG2 full-scale samples fit exactly.
  assign acc0_sum     = acc0 + ACC_W'(adc_data);
  assign acc1_sum     = acc1 + ACC_W'(adc_data);
  assign pair_cnt_inc = pair_cnt + CNT_W'(1);

  // Fixed MCP3202 configuration: single-ended, MSB-first.
  assign sgl_diff = 1'b1;
  assign msb_lsb  = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start       <= 1'b0;
      odd_sign    <= 1'b0;
      ch0_avg     <= 12'd0;
      ch1_avg     <= 12'd0;
      avg_valid   <= 1'b0;
      timeout_err <= 1'b0;
      period_cnt  <= 16'd0;
      wait_cnt    <= 16'd0;
      acc0        <= '0;
      acc1        <= '0;
      pair_cnt    <= '0;
    end else begin
      start     <= 1'b0;
      avg_valid <= 1'b0;

      // Free-running saturating down-counter; the START branch below reloads it.
      if (period_cnt != 16'd0) begin
        period_cnt <= period_cnt - 16'd1;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state <= START;
            start <= 1'b1;
          end
        end

        START: begin
          period_cnt <= PERIOD_LOAD;
          wait_cnt   <= 16'd0;
          state      <= WAIT_LOW;
        end

        WAIT_LOW: begin
          if (!chipselect) begin
            wait_cnt <= 16'd0;
            state    <= WAIT_HIGH;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            // Stalled before the conversion began: drop it, keep the channel.
            timeout_err <= 1'b1;
            state       <= GAP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        WAIT_HIGH: begin
          if (chipselect) begin
            state <= CAPTURE;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            state       <= GAP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        CAPTURE: begin
          state    <= GAP;
          odd_sign <= ~odd_sign;
          if (!odd_sign) begin
            acc0 <= acc0_sum;
          end else if (pair_cnt_inc == CNT_FULL) begin
            // Last CH1 sample of the window: publish both averages and restart.
            ch0_avg   <= acc0[AVG_LOG2 +: 12];
            ch1_avg   <= acc1_sum[AVG_LOG2 +: 12];
            avg_valid <= 1'b1;
            acc0      <= '0;
            acc1      <= '0;
            pair_cnt  <= '0;
          end else begin
            acc1     <= acc1_sum;
            pair_cnt <= pair_cnt_inc;
          end
        end

        GAP: begin
          // The counter hits 0 at the end of this cycle when it reads 1 here, so
          // leaving now lands the next START exactly SAMPLE_PERIOD after the
          // previous one. An overrun conversion finds it already at 0.
          if (period_cnt <= 16'd1) begin
            if (enable) begin
              state <= START;
              start <= 1'b1;
            end else begin
              state       <= IDLE;
              acc0        <= '0;
              acc1        <= '0;
              pair_cnt    <= '0;
              odd_sign    <= 1'b0;
              timeout_err <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_scan_sequencer
//
// Directed bench for adc_scan_sequencer. Two instances: a main one
// (SAMPLE_PERIOD=200, AVG_LOG2=2, TIMEOUT=50) and a fast one
// (SAMPLE_PERIOD=10) whose period is shorter than a conversion. Each has a
// small SPI slave model: chip-select drops CS_DELAY cycles after start, stays
// low CS_LOW cycles, then rises with the next queued code for that channel.
// -----------------------------------------------------------------------------
module tb_adc_scan_sequencer;

  localparam int CS_DELAY = 2;
  localparam int CS_LOW   = 20;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        enable_a = 1'b0;
  logic        enable_b = 1'b0;

  logic        start_a, sgl_a, odd_a, msb_a, valid_a, err_a;
  logic [11:0] avg0_a, avg1_a;
  logic        cs_a  = 1'b1;
  logic [11:0] adc_a = 12'h000;

  logic        start_b, sgl_b, odd_b, msb_b, valid_b, err_b;
  logic [11:0] avg0_b, avg1_b;
  logic        cs_b  = 1'b1;
  logic [11:0] adc_b = 12'h000;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_start_a = 0;
  int n_valid_a = 0;
  int cs_rise_a = 0;
  bit stall_a = 1'b0;
  logic [11:0] q0[$];
  logic [11:0] q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_scan_sequencer #(.SAMPLE_PERIOD(200), .AVG_LOG2(2), .TIMEOUT(50)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable_a),
    .start(start_a), .sgl_diff(sgl_a), .odd_sign(odd_a), .msb_lsb(msb_a),
    .chipselect(cs_a), .adc_data(adc_a),
    .ch0_avg(avg0_a), .ch1_avg(avg1_a), .avg_valid(valid_a), .timeout_err(err_a)
  );

  adc_scan_sequencer #(.SAMPLE_PERIOD(10), .AVG_LOG2(2), .TIMEOUT(50)) dut_fast (
    .clk(clk), .rst_n(rst_n), .enable(enable_b),
    .start(start_b), .sgl_diff(sgl_b), .odd_sign(odd_b), .msb_lsb(msb_b),
    .chipselect(cs_b), .adc_data(adc_b),
    .ch0_avg(avg0_b), .ch1_avg(avg1_b), .avg_valid(valid_b), .timeout_err(err_b)
  );

  // Slave model for the main instance, driven on the falling edge.
  int   sa_phase = 0;
  int   sa_cnt   = 0;
  logic sa_ch    = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      sa_phase <= 0;
      cs_a     <= 1'b1;
    end else begin
      case (sa_phase)
        0: if (start_a && !stall_a) begin
             sa_ch    <= odd_a;
             sa_cnt   <= CS_DELAY;
             sa_phase <= 1;
           end
        1: if (sa_cnt == 1) begin
             cs_a     <= 1'b0;
             sa_cnt   <= CS_LOW;
             sa_phase <= 2;
           end else begin
             sa_cnt <= sa_cnt - 1;
           end
        2: if (sa_cnt == 1) begin
             if (sa_ch == 1'b0 && q0.size() > 0) adc_a <= q0.pop_front();
             else if (sa_ch == 1'b1 && q1.size() > 0) adc_a <= q1.pop_front();
             else adc_a <= 12'h000;
             cs_a      <= 1'b1;
             cs_rise_a <= cyc;
             sa_phase  <= 0;
           end else begin
             sa_cnt <= sa_cnt - 1;
           end
        default: sa_phase <= 0;
      endcase
    end
  end

  // Slave model for the fast instance: same timing, constant code.
  int sb_phase = 0;
  int sb_cnt   = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_phase <= 0;
      cs_b     <= 1'b1;
    end else begin
      case (sb_phase)
        0: if (start_b) begin
             sb_cnt   <= CS_DELAY;
             sb_phase <= 1;
           end
        1: if (sb_cnt == 1) begin
             cs_b     <= 1'b0;
             sb_cnt   <= CS_LOW;
             sb_phase <= 2;
           end else begin
             sb_cnt <= sb_cnt - 1;
           end
        2: if (sb_cnt == 1) begin
             adc_b    <= 12'h055;
             cs_b     <= 1'b1;
             sb_phase <= 0;
           end else begin
             sb_cnt <= sb_cnt - 1;
           end
        default: sb_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (start_a) n_start_a <= n_start_a + 1;
    if (valid_a) n_valid_a <= n_valid_a + 1;
  end

  // ---------------------------------------------------------------- waits
  task automatic wait_start_a(input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (start_a === 1'b1) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic wait_start_b(input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (start_b === 1'b1) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic wait_valid_a(input int budget, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid_a === 1'b1) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic wait_cs_a(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cs_a === level) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({start_a, sgl_a, odd_a, msb_a, valid_a, err_a} !== 6'b010100) begin
      n_bad++;
      $display("FAIL reset_ctrl_a: got %b want 010100", {start_a, sgl_a, odd_a, msb_a, valid_a, err_a});
    end
    n_cmp++;
    if ({avg0_a, avg1_a} !== 24'h000000) begin
      n_bad++;
      $display("FAIL reset_avg_a: got %h/%h want 000/000", avg0_a, avg1_a);
    end
    n_cmp++;
    if ({start_b, sgl_b, odd_b, msb_b, valid_b, err_b} !== 6'b010100) begin
      n_bad++;
      $display("FAIL reset_ctrl_b: got %b want 010100", {start_b, sgl_b, odd_b, msb_b, valid_b, err_b});
    end
    n_cmp++;
    if ({avg0_b, avg1_b} !== 24'h000000) begin
      n_bad++;
      $display("FAIL reset_avg_b: got %h/%h want 000/000", avg0_b, avg1_b);
    end
    rst_n = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_constant_codes();
    int s, prev, v, vbase;
    bit ok;
    logic exp_odd;
    q0.delete(); q1.delete();
    for (int i = 0; i < 4; i++) begin q0.push_back(12'h123); q1.push_back(12'hABC); end
    vbase = n_valid_a;
    prev = 0;
    enable_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_start_a(400, s, ok);
      n_cmp++;
      if (ok !== 1'b1) begin n_bad++; $display("FAIL const_start%0d: got no start want start", i); end
      exp_odd = (i % 2 == 1);
      n_cmp++;
      if (odd_a !== exp_odd) begin n_bad++; $display("FAIL const_odd%0d: got %b want %b", i, odd_a, exp_odd); end
      if (i > 0) begin
        n_cmp++;
        if (s - prev != 200) begin n_bad++; $display("FAIL const_period%0d: got %0d want 200", i, s - prev); end
      end
      prev = s;
      @(negedge clk);
      n_cmp++;
      if (start_a !== 1'b0) begin n_bad++; $display("FAIL const_start_width%0d: got %b want 0", i, start_a); end
      $display("const conv %0d: start at cycle %0d odd_sign=%b", i, s, exp_odd);
    end
    wait_valid_a(400, v, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL const_valid: got no avg_valid want pulse"); end
    n_cmp++;
    if (v - cs_rise_a != 2) begin n_bad++; $display("FAIL const_valid_latency: got %0d want 2", v - cs_rise_a); end
    n_cmp++;
    if (avg0_a !== 12'h123) begin n_bad++; $display("FAIL const_ch0: got %h want 123", avg0_a); end
    n_cmp++;
    if (avg1_a !== 12'hABC) begin n_bad++; $display("FAIL const_ch1: got %h want abc", avg1_a); end
    enable_a = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (valid_a !== 1'b0) begin n_bad++; $display("FAIL const_valid_width: got %b want 0", valid_a); end
    n_cmp++;
    if (n_valid_a - vbase != 1) begin n_bad++; $display("FAIL const_valid_count: got %0d want 1", n_valid_a - vbase); end
    $display("test_constant_codes: ch0=%h ch1=%h", avg0_a, avg1_a);
    repeat (400) @(negedge clk);
  endtask

  task automatic test_truncation();
    int v, sbase;
    bit ok;
    q0.delete(); q1.delete();
    for (int i = 0; i < 4; i++) begin q0.push_back(12'(100 + i)); q1.push_back(12'd4095); end
    sbase = n_start_a;
    enable_a = 1'b1;
    wait_valid_a(2500, v, ok);
    enable_a = 1'b0;
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL trunc_valid: got no avg_valid want pulse"); end
    n_cmp++;
    if (n_start_a - sbase != 8) begin n_bad++; $display("FAIL trunc_starts: got %0d want 8", n_start_a - sbase); end
    n_cmp++;
    if (avg0_a !== 12'd101) begin n_bad++; $display("FAIL trunc_ch0: got %0d want 101", avg0_a); end
    n_cmp++;
    if (avg1_a !== 12'd4095) begin n_bad++; $display("FAIL trunc_ch1: got %0d want 4095", avg1_a); end
    repeat (300) @(negedge clk);
    n_cmp++;
    if ({avg0_a, avg1_a} !== {12'd101, 12'd4095}) begin
      n_bad++;
      $display("FAIL trunc_hold: got %0d/%0d want 101/4095", avg0_a, avg1_a);
    end
    $display("test_truncation: ch0=%0d ch1=%0d", avg0_a, avg1_a);
    repeat (100) @(negedge clk);
  endtask

  task automatic test_stall();
    int s0, s1, s2, v;
    bit ok;
    q0.delete(); q1.delete();
    for (int i = 0; i < 4; i++) begin q0.push_back(12'h010); q1.push_back(12'h800); end
    stall_a = 1'b0;
    enable_a = 1'b1;
    wait_start_a(400, s0, ok);
    @(negedge clk);
    stall_a = 1'b1;
    wait_start_a(400, s1, ok);
    n_cmp++;
    if (ok !== 1'b1 || odd_a !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_ch1_start: got seen=%b odd=%b want seen=1 odd=1", ok, odd_a);
    end
    repeat (50) @(negedge clk);
    n_cmp++;
    if (err_a !== 1'b0) begin n_bad++; $display("FAIL stall_err_early: got %b want 0", err_a); end
    @(negedge clk);
    n_cmp++;
    if (err_a !== 1'b1) begin n_bad++; $display("FAIL stall_err_at_timeout: got %b want 1", err_a); end
    stall_a = 1'b0;
    wait_start_a(400, s2, ok);
    n_cmp++;
    if (odd_a !== 1'b1) begin n_bad++; $display("FAIL stall_retry_channel: got %b want 1", odd_a); end
    n_cmp++;
    if (s2 - s1 != 200) begin n_bad++; $display("FAIL stall_retry_period: got %0d want 200", s2 - s1); end
    wait_valid_a(2500, v, ok);
    n_cmp++;
    if (ok !== 1'b1 || {avg0_a, avg1_a} !== {12'h010, 12'h800}) begin
      n_bad++;
      $display("FAIL stall_avgs: got seen=%b %h/%h want seen=1 010/800", ok, avg0_a, avg1_a);
    end
    n_cmp++;
    if (err_a !== 1'b1) begin n_bad++; $display("FAIL stall_err_sticky: got %b want 1", err_a); end
    enable_a = 1'b0;
    repeat (400) @(negedge clk);
    n_cmp++;
    if (err_a !== 1'b0) begin n_bad++; $display("FAIL stall_err_idle_clear: got %b want 0", err_a); end
    $display("test_stall: stall start at %0d retry at %0d", s1, s2);
  endtask

  task automatic test_enable_drop();
    int s, v, sbase, extra;
    bit ok;
    q0.delete(); q1.delete();
    q0.push_back(12'hFFF);
    q1.push_back(12'hFFF);
    enable_a = 1'b1;
    wait_start_a(400, s, ok);
    wait_start_a(400, s, ok);
    n_cmp++;
    if (ok !== 1'b1 || odd_a !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_ch1_start: got seen=%b odd=%b want seen=1 odd=1", ok, odd_a);
    end
    wait_cs_a(1'b0, 100, ok);
    enable_a = 1'b0;
    wait_cs_a(1'b1, 100, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL drop_conv_complete: got cs low want cs high"); end
    extra = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (start_a === 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin n_bad++; $display("FAIL drop_no_start: got %0d starts want 0", extra); end
    q0.delete(); q1.delete();
    for (int i = 0; i < 4; i++) begin q0.push_back(12'h004); q1.push_back(12'h008); end
    sbase = n_start_a;
    enable_a = 1'b1;
    wait_start_a(400, s, ok);
    n_cmp++;
    if (odd_a !== 1'b0) begin n_bad++; $display("FAIL drop_restart_ch0: got %b want 0", odd_a); end
    wait_valid_a(2500, v, ok);
    n_cmp++;
    if (n_start_a - sbase != 8) begin n_bad++; $display("FAIL drop_full_window: got %0d starts want 8", n_start_a - sbase); end
    n_cmp++;
    if ({avg0_a, avg1_a} !== {12'h004, 12'h008}) begin
      n_bad++;
      $display("FAIL drop_avgs: got %h/%h want 004/008", avg0_a, avg1_a);
    end
    enable_a = 1'b0;
    $display("test_enable_drop: ch0=%h ch1=%h", avg0_a, avg1_a);
    repeat (400) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int s, v, sbase;
    bit ok;
    q0.delete(); q1.delete();
    q0.push_back(12'h111);
    enable_a = 1'b1;
    wait_start_a(400, s, ok);
    wait_start_a(400, s, ok);
    wait_cs_a(1'b0, 100, ok);
    n_cmp++;
    if (odd_a !== 1'b1 || avg0_a !== 12'h004) begin
      n_bad++;
      $display("FAIL rmid_pre: got odd=%b ch0=%h want odd=1 ch0=004", odd_a, avg0_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (odd_a !== 1'b0) begin n_bad++; $display("FAIL rmid_odd_async: got %b want 0", odd_a); end
    n_cmp++;
    if ({avg0_a, avg1_a} !== 24'h000000) begin
      n_bad++;
      $display("FAIL rmid_avg_async: got %h/%h want 000/000", avg0_a, avg1_a);
    end
    q0.delete(); q1.delete();
    for (int i = 0; i < 4; i++) begin q0.push_back(12'h050); q1.push_back(12'h060); end
    sbase = n_start_a;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_start_a(400, s, ok);
    n_cmp++;
    if (ok !== 1'b1 || odd_a !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_restart_ch0: got seen=%b odd=%b want seen=1 odd=0", ok, odd_a);
    end
    wait_valid_a(2500, v, ok);
    n_cmp++;
    if (n_start_a - sbase != 8) begin n_bad++; $display("FAIL rmid_full_window: got %0d starts want 8", n_start_a - sbase); end
    n_cmp++;
    if ({avg0_a, avg1_a} !== {12'h050, 12'h060}) begin
      n_bad++;
      $display("FAIL rmid_avgs: got %h/%h want 050/060", avg0_a, avg1_a);
    end
    enable_a = 1'b0;
    $display("test_reset_mid: ch0=%h ch1=%h", avg0_a, avg1_a);
    repeat (400) @(negedge clk);
  endtask

  task automatic test_overrun();
    int s1, s2, s3;
    bit ok1, ok2, ok3;
    enable_b = 1'b1;
    wait_start_b(100, s1, ok1);
    wait_start_b(100, s2, ok2);
    wait_start_b(100, s3, ok3);
    enable_b = 1'b0;
    // CS drops 3 cycles after START, low 20 cycles, CAPTURE next, one GAP cycle.
    n_cmp++;
    if (ok1 !== 1'b1 || ok2 !== 1'b1 || s2 - s1 != 25) begin
      n_bad++;
      $display("FAIL overrun_gap1: got %0d want 25", s2 - s1);
    end
    n_cmp++;
    if (ok3 !== 1'b1 || s3 - s2 != 25) begin
      n_bad++;
      $display("FAIL overrun_gap2: got %0d want 25", s3 - s2);
    end
    $display("test_overrun: starts at %0d %0d %0d", s1, s2, s3);
  endtask

  initial begin
    test_reset();
    test_constant_codes();
    test_truncation();
    test_stall();
    test_enable_drop();
    test_reset_mid();
    test_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
